// File: rtl/hive_thd_alarm_if.sv
// Register-bus bundle between a thread issuing rbus accesses and the alarm unit.
interface hive_thd_alarm_if #(
    parameter int unsigned THD_W       = 3,
    parameter int unsigned ALU_W       = 32,
    parameter int unsigned RBUS_ADDR_W = 8
);
    logic [THD_W-1:0]       id;
    logic [RBUS_ADDR_W-1:0] rbus_addr;
    logic                   rbus_wr;
    logic                   rbus_rd;
    logic [ALU_W-1:0]       rbus_wr_data;
    logic [ALU_W-1:0]       rbus_rd_data;

    modport master (
        output id, rbus_addr, rbus_wr, rbus_rd, rbus_wr_data,
        input  rbus_rd_data
    );

    modport slave (
        input  id, rbus_addr, rbus_wr, rbus_rd, rbus_wr_data,
        output rbus_rd_data
    );
endinterface

// File: rtl/hive_thd_alarm.sv
// Per-thread alarm unit: each thread arms a compare value against the ring time
// and gets a pending flag once time reaches it (wrap-safe).
module hive_thd_alarm #(
    parameter int unsigned THREADS     = 8,
    parameter int unsigned THD_W       = 3,
    parameter int unsigned ALU_W       = 32,
    parameter int unsigned RBUS_ADDR_W = 8,
    parameter int unsigned ADDR_ARM    = 'h20,
    parameter int unsigned ADDR_STAT   = 'h21
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [ALU_W-1:0]   time_i,
    output logic [THREADS-1:0] alarm_o,
    hive_thd_alarm_if.slave    rbus
);

    localparam int unsigned MSB = ALU_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_e;

    state_e             state_q [THREADS];
    state_e             state_d [THREADS];
    logic [ALU_W-1:0]   cmp_q   [THREADS];
    logic [ALU_W-1:0]   cmp_d   [THREADS];
    logic [ALU_W-1:0]   diff_c  [THREADS];
    logic [THREADS-1:0] fired_c;
    logic [THREADS-1:0] alarm_q, alarm_d;
    logic [ALU_W-1:0]   rd_data_q, rd_data_d;

    logic wr_arm_c, wr_stat_c, rd_arm_c, rd_stat_c;

    assign wr_arm_c  = rbus.rbus_wr && (rbus.rbus_addr == RBUS_ADDR_W'(ADDR_ARM));
    assign wr_stat_c = rbus.rbus_wr && (rbus.rbus_addr == RBUS_ADDR_W'(ADDR_STAT));
    assign rd_arm_c  = rbus.rbus_rd && (rbus.rbus_addr == RBUS_ADDR_W'(ADDR_ARM));
    assign rd_stat_c = rbus.rbus_rd && (rbus.rbus_addr == RBUS_ADDR_W'(ADDR_STAT));

    // Per-thread signed distance past the compare value and current FIRED vector
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            diff_c[t]  = time_i - cmp_q[t];
            fired_c[t] = (state_q[t] == ST_FIRED);
        end
    end

    // Next-state, compare update and registered-output values
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            state_d[t] = state_q[t];
            cmp_d[t]   = cmp_q[t];
        end
        rd_data_d = '0;
        alarm_d   = fired_c;

        if (rd_stat_c) begin
            rd_data_d = ALU_W'(fired_c);
        end else if (rd_arm_c && (state_q[rbus.id] == ST_ARMED)) begin
            rd_data_d = cmp_q[rbus.id] - time_i;
        end

        // Arm beats disarm beats evaluation; a fresh cmp is first evaluated next cycle
        for (int t = 0; t < THREADS; t++) begin
            if (wr_arm_c && (rbus.id == THD_W'(t))) begin
                cmp_d[t]   = rbus.rbus_wr_data;
                state_d[t] = ST_ARMED;
            end else if (wr_stat_c && (rbus.id == THD_W'(t))) begin
                state_d[t] = ST_IDLE;
            end else begin
                unique case (state_q[t])
                    ST_ARMED: if (!diff_c[t][MSB]) state_d[t] = ST_FIRED;
                    ST_FIRED: if (rd_stat_c && (rbus.id == THD_W'(t))) state_d[t] = ST_IDLE;
                    default:  state_d[t] = state_q[t];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int t = 0; t < THREADS; t++) begin
                state_q[t] <= ST_IDLE;
                cmp_q[t]   <= '0;
            end
            alarm_q   <= '0;
            rd_data_q <= '0;
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                state_q[t] <= state_d[t];
                cmp_q[t]   <= cmp_d[t];
            end
            alarm_q   <= alarm_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign alarm_o           = alarm_q;
    assign rbus.rbus_rd_data = rd_data_q;

endmodule

// File: tb/tb_hive_thd_alarm.sv
// Directed bench for hive_thd_alarm: vector table plus multi-cycle corner sequences.
module tb_hive_thd_alarm;

    localparam logic [7:0] A_ARM  = 8'h20;
    localparam logic [7:0] A_STAT = 8'h21;

    typedef struct {
        logic [31:0] tm;
        logic [2:0]  id;
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_al;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tm = '0;
    logic [7:0]  alarm;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        vecs[$];

    hive_thd_alarm_if #(.THD_W(3), .ALU_W(32), .RBUS_ADDR_W(8)) rbus ();

    hive_thd_alarm dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .time_i  (tm),
        .alarm_o (alarm),
        .rbus    (rbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 'h%0h, expected 'h%0h (time_i='h%0h)", name, act, exp, tm);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [2:0] id, input logic wr, input logic rd,
                         input logic [7:0] addr, input logic [31:0] wdata);
        rbus.id           = id;
        rbus.rbus_wr      = wr;
        rbus.rbus_rd      = rd;
        rbus.rbus_addr    = addr;
        rbus.rbus_wr_data = wdata;
    endtask

    task automatic idle();
        drive(3'd0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // One clock: inputs held for the cycle, outputs observed just after the edge
    task automatic step();
        @(posedge clk);
        #1;
        tm = tm + 32'd1;
    endtask

    task automatic add(input logic [31:0] t, input logic [2:0] id, input logic wr, input logic rd,
                       input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic [7:0] eal);
        vec_t v;
        v.tm = t; v.id = id; v.wr = wr; v.rd = rd; v.addr = addr;
        v.wdata = wd; v.exp_rd = erd; v.exp_al = eal;
        vecs.push_back(v);
    endtask

    initial begin
        // Thread 2: arm 'h105 at 'h100, alarm visible at 'h107, cleared by its STAT read
        add(32'h100, 3'd2, 1'b1, 1'b0, A_ARM,  32'h105, 32'h0,  8'h00);
        add(32'h101, 3'd2, 1'b0, 1'b1, A_ARM,  32'h0,   32'h4,  8'h00);
        add(32'h102, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        add(32'h103, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        add(32'h104, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        add(32'h105, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        add(32'h106, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h04);
        add(32'h107, 3'd2, 1'b0, 1'b1, A_STAT, 32'h0,   32'h4,  8'h04);
        add(32'h108, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        // Thread 1: cmp in the past fires on first evaluation
        add(32'h200, 3'd1, 1'b1, 1'b0, A_ARM,  32'h1F6, 32'h0,  8'h00);
        add(32'h201, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        add(32'h202, 3'd1, 1'b0, 1'b1, A_ARM,  32'h0,   32'h0,  8'h02);
        add(32'h203, 3'd1, 1'b0, 1'b1, A_STAT, 32'h0,   32'h2,  8'h02);
        add(32'h204, 3'd1, 1'b0, 1'b1, A_STAT, 32'h0,   32'h0,  8'h00);
        // Thread 4: simultaneous read+re-arm, then STAT write disarms
        add(32'h300, 3'd4, 1'b1, 1'b0, A_ARM,  32'h400, 32'h0,  8'h00);
        add(32'h301, 3'd4, 1'b1, 1'b1, A_ARM,  32'h500, 32'hFF, 8'h00);
        add(32'h302, 3'd4, 1'b0, 1'b1, A_ARM,  32'h0,   32'h1FE,8'h00);
        add(32'h303, 3'd4, 1'b1, 1'b0, A_STAT, 32'hDEAD,32'h0,  8'h00);
        add(32'h304, 3'd4, 1'b0, 1'b1, A_ARM,  32'h0,   32'h0,  8'h00);
        add(32'h500, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        add(32'h501, 3'd0, 1'b0, 1'b0, 8'h00,  32'h0,   32'h0,  8'h00);
        add(32'h502, 3'd0, 1'b0, 1'b1, 8'h22,  32'h0,   32'h0,  8'h00);

        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_alarm", 32'(alarm), 32'h0);
        check("reset_rd", rbus.rbus_rd_data, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            tm = vecs[i].tm;
            drive(vecs[i].id, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            step();
            check($sformatf("vec%0d_rd", i), rbus.rbus_rd_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(vecs[i].exp_al));
        end

        // Thread 5 arms across the time rollover
        tm = 32'hFFFF_FFFE;
        drive(3'd5, 1'b1, 1'b0, A_ARM, 32'h3);
        step();
        drive(3'd5, 1'b0, 1'b1, A_ARM, 32'h0);
        step();
        check("wrap_remaining", rbus.rbus_rd_data, 32'h4);
        idle();
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("wrap_alarm_t%0d", tm), 32'(alarm), (tm >= 32'd5) ? 32'h20 : 32'h0);
        end
        drive(3'd5, 1'b0, 1'b1, A_STAT, 32'h0);
        step();
        check("wrap_stat", rbus.rbus_rd_data, 32'h20);
        idle();
        step();
        check("wrap_cleared", 32'(alarm), 32'h0);

        // Thread 3 re-arms in the cycle its old cmp is due
        tm = 32'h600;
        drive(3'd3, 1'b1, 1'b0, A_ARM, 32'h605);
        step();
        idle();
        for (int k = 0; k < 4; k++) step();
        drive(3'd3, 1'b1, 1'b0, A_ARM, 32'h60A);
        step();
        idle();
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("rearm_alarm_t%0h", tm), 32'(alarm), (tm >= 32'h60C) ? 32'h8 : 32'h0);
        end
        drive(3'd3, 1'b0, 1'b1, A_STAT, 32'h0);
        step();
        check("rearm_stat", rbus.rbus_rd_data, 32'h8);

        // Reset while threads 0/6/7 armed and thread 2 fired
        tm = 32'h700;
        drive(3'd2, 1'b1, 1'b0, A_ARM, 32'h0);
        step();
        drive(3'd0, 1'b1, 1'b0, A_ARM, 32'h710);
        step();
        drive(3'd6, 1'b1, 1'b0, A_ARM, 32'h710);
        step();
        check("pre_rst_alarm", 32'(alarm), 32'h4);
        drive(3'd7, 1'b1, 1'b0, A_ARM, 32'h710);
        step();
        drive(3'd0, 1'b0, 1'b1, A_STAT, 32'h0);
        step();
        check("pre_rst_rd", rbus.rbus_rd_data, 32'h4);
        idle();
        rst_n = 1'b0;
        #1;
        check("async_rst_alarm", 32'(alarm), 32'h0);
        check("async_rst_rd", rbus.rbus_rd_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("post_rst_alarm_t%0h", tm), 32'(alarm), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
